// File: rtl/fpu_norm_shift.sv
// rtl/fpu_norm_shift.sv - two-stage post-add/sub normaliser with leading-zero counter
//
// fpu_utils_lzc
//   Purpose : combinational leading-zero counter, counted from the MSB.
//   Ports   : in_i    [WIDTH-1:0]  value to scan
//             cnt_o   [CW-1:0]     number of zeros above the highest set bit
//             empty_o              in_i is all zero (cnt_o is 0 and meaningless)
//
// fpu_norm_shift
//   Purpose : sits between the FPU adder datapath and the rounding stage.
//             Stage 1 registers the raw beat together with its leading-zero
//             count; stage 2 left-shifts the mantissa and lowers the exponent,
//             clamping the shift so the exponent never drops below 1 (the
//             result is then a denormal with out_mant_o[MSB] clear).
//   Ports   : clk_i, rst_i (sync, active-high), flush_i (sync pipeline flush)
//             in_valid_i/in_ready_o   input handshake
//             in_sign_i, in_exp_i (signed, EXPW bits), in_mant_i (MANT_WIDTH)
//             out_valid_o/out_ready_i output handshake
//             out_sign_o, out_exp_o, out_mant_o, out_zero_o, out_denorm_o

module fpu_utils_lzc #(
  parameter  int WIDTH = 51,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o,
  output logic             empty_o
);

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) begin
        cnt_o   = CW'(WIDTH - 1 - i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

module fpu_norm_shift #(
  parameter  int MANT_WIDTH = 51,
  parameter  int EXP_WIDTH  = 11,
  localparam int EXPW       = EXP_WIDTH + 2,
  localparam int LZW        = (MANT_WIDTH > 1) ? $clog2(MANT_WIDTH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   in_sign_i,
  input  logic signed [EXPW-1:0] in_exp_i,
  input  logic [MANT_WIDTH-1:0]  in_mant_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_sign_o,
  output logic signed [EXPW-1:0] out_exp_o,
  output logic [MANT_WIDTH-1:0]  out_mant_o,
  output logic                   out_zero_o,
  output logic                   out_denorm_o
);

  localparam logic signed [EXPW-1:0] EXP_ONE = EXPW'(1);

  // Stage 1 registers
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_sign_q,  s1_sign_d;
  logic signed [EXPW-1:0] s1_exp_q,   s1_exp_d;
  logic [MANT_WIDTH-1:0]  s1_mant_q,  s1_mant_d;
  logic [LZW-1:0]         s1_lzc_q,   s1_lzc_d;
  logic                   s1_zero_q,  s1_zero_d;

  // Stage 2 (output) registers
  logic                   out_valid_q,  out_valid_d;
  logic                   out_sign_q,   out_sign_d;
  logic signed [EXPW-1:0] out_exp_q,    out_exp_d;
  logic [MANT_WIDTH-1:0]  out_mant_q,   out_mant_d;
  logic                   out_zero_q,   out_zero_d;
  logic                   out_denorm_q, out_denorm_d;

  logic                   s2_adv;
  logic                   s1_adv;
  logic [LZW-1:0]         lzc_cnt;
  logic                   lzc_empty;

  logic [EXPW-1:0]        lzc_ext;
  logic [EXPW-1:0]        max_sh;
  logic [EXPW-1:0]        sh;
  logic [MANT_WIDTH-1:0]  mant_shifted;
  logic signed [EXPW-1:0] exp_adjusted;

  fpu_utils_lzc #(
    .WIDTH (MANT_WIDTH)
  ) u_lzc (
    .in_i    (in_mant_i),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  // A stage may load whenever its register is empty or its contents leave
  // this cycle, so a stalled output backs up into stage 1 before in_ready_o
  // drops.
  always_comb begin
    s2_adv = ~out_valid_q | out_ready_i;
    s1_adv = ~s1_valid_q | s2_adv;
  end

  assign in_ready_o = s1_adv;

  // Stage 1 next state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_lzc_d   = s1_lzc_q;
    s1_zero_d  = s1_zero_q;
    if (s1_adv) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_sign_d = in_sign_i;
        s1_exp_d  = in_exp_i;
        s1_mant_d = in_mant_i;
        s1_lzc_d  = lzc_cnt;
        s1_zero_d = lzc_empty;
      end
    end
    // Flush wins over accept: the beat offered this cycle is dropped.
    if (flush_i) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 shift amount: normalise fully unless that would take the
  // exponent below 1, in which case stop at exponent 1 (denormal result).
  always_comb begin
    lzc_ext = EXPW'(s1_lzc_q);
    if (s1_exp_q > EXP_ONE) begin
      max_sh = s1_exp_q - EXP_ONE;
    end else begin
      max_sh = '0;
    end
    sh           = (lzc_ext < max_sh) ? lzc_ext : max_sh;
    mant_shifted = s1_mant_q << sh;
    exp_adjusted = s1_exp_q - $signed(sh);
  end

  // Stage 2 next state
  always_comb begin
    out_valid_d  = out_valid_q;
    out_sign_d   = out_sign_q;
    out_exp_d    = out_exp_q;
    out_mant_d   = out_mant_q;
    out_zero_d   = out_zero_q;
    out_denorm_d = out_denorm_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d = s1_sign_q;
        if (s1_zero_q) begin
          out_exp_d    = '0;
          out_mant_d   = '0;
          out_zero_d   = 1'b1;
          out_denorm_d = 1'b0;
        end else begin
          out_exp_d    = exp_adjusted;
          out_mant_d   = mant_shifted;
          out_zero_d   = 1'b0;
          out_denorm_d = ~mant_shifted[MANT_WIDTH-1];
        end
      end
    end
    if (flush_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      s1_lzc_q     <= '0;
      s1_zero_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sign_q   <= 1'b0;
      out_exp_q    <= '0;
      out_mant_q   <= '0;
      out_zero_q   <= 1'b0;
      out_denorm_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_mant_q    <= s1_mant_d;
      s1_lzc_q     <= s1_lzc_d;
      s1_zero_q    <= s1_zero_d;
      out_valid_q  <= out_valid_d;
      out_sign_q   <= out_sign_d;
      out_exp_q    <= out_exp_d;
      out_mant_q   <= out_mant_d;
      out_zero_q   <= out_zero_d;
      out_denorm_q <= out_denorm_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_sign_o   = out_sign_q;
  assign out_exp_o    = out_exp_q;
  assign out_mant_o   = out_mant_q;
  assign out_zero_o   = out_zero_q;
  assign out_denorm_o = out_denorm_q;

endmodule

// File: tb/tb_fpu_norm_shift.sv
// tb/tb_fpu_norm_shift.sv - self-checking bench for fpu_norm_shift

module tb_fpu_norm_shift;

  localparam int MW   = 51;
  localparam int EW   = 11;
  localparam int EXPW = EW + 2;

  typedef struct packed {
    logic            sign;
    logic [EXPW-1:0] expo;
    logic [MW-1:0]   mant;
    logic            zero;
    logic            denorm;
  } res_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic            in_sign_i;
  logic [EXPW-1:0] in_exp_i;
  logic [MW-1:0]   in_mant_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic            out_sign_o;
  logic [EXPW-1:0] out_exp_o;
  logic [MW-1:0]   out_mant_o;
  logic            out_zero_o;
  logic            out_denorm_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  res_t exp_q[$];

  fpu_norm_shift #(
    .MANT_WIDTH (MW),
    .EXP_WIDTH  (EW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_sign_i    (in_sign_i),
    .in_exp_i     (in_exp_i),
    .in_mant_i    (in_mant_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_sign_o   (out_sign_o),
    .out_exp_o    (out_exp_o),
    .out_mant_o   (out_mant_o),
    .out_zero_o   (out_zero_o),
    .out_denorm_o (out_denorm_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Reference: normalise one bit at a time while the hidden bit is clear and
  // the exponent is still above 1.
  function automatic res_t ref_model(input logic s, input logic [EXPW-1:0] e_in,
                                     input logic [MW-1:0] m_in);
    res_t          r;
    int            e;
    logic [MW-1:0] m;
    e      = int'($signed(e_in));
    m      = m_in;
    r.sign = s;
    if (m == '0) begin
      r.expo   = '0;
      r.mant   = '0;
      r.zero   = 1'b1;
      r.denorm = 1'b0;
      return r;
    end
    while (!m[MW-1] && e > 1) begin
      m = m << 1;
      e = e - 1;
    end
    r.expo   = EXPW'(e);
    r.mant   = m;
    r.zero   = 1'b0;
    r.denorm = !m[MW-1];
    return r;
  endfunction

  function automatic logic [MW-1:0] bit_at(input int k);
    logic [MW-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic res_t mk(input logic s, input int e, input logic [MW-1:0] m,
                              input logic z, input logic d);
    res_t r;
    r.sign   = s;
    r.expo   = EXPW'(e);
    r.mant   = m;
    r.zero   = z;
    r.denorm = d;
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.sign   = out_sign_o;
    r.expo   = out_exp_o;
    r.mant   = out_mant_o;
    r.zero   = out_zero_o;
    r.denorm = out_denorm_o;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_res(input string tag, input res_t o, input res_t e);
    check({tag, ".sign"},   64'(o.sign),   64'(e.sign));
    check({tag, ".exp"},    64'(o.expo),   64'(e.expo));
    check({tag, ".mant"},   64'(o.mant),   64'(e.mant));
    check({tag, ".zero"},   64'(o.zero),   64'(e.zero));
    check({tag, ".denorm"}, 64'(o.denorm), 64'(e.denorm));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid_o), 64'd0);
    check({tag, ".in_ready"},  64'(in_ready_o),  64'd1);
    check_res(tag, observed(), mk(1'b0, 0, '0, 1'b0, 1'b0));
  endtask

  task automatic drive(input logic v, input logic s, input logic [EXPW-1:0] e,
                       input logic [MW-1:0] m, input logic rdy);
    in_valid_i  = v;
    in_sign_i   = s;
    in_exp_i    = e;
    in_mant_i   = m;
    out_ready_i = rdy;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Scoreboard for one cycle; call #1 after the inputs were driven.
  task automatic sb_cycle(input string tag);
    res_t e;
    if (out_valid_o && out_ready_i) begin
      check({tag, ".expected_beat"}, 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_res(tag, observed(), e);
        n_out++;
      end
    end
    if (in_valid_i && in_ready_o && !flush_i && !rst_i)
      exp_q.push_back(ref_model(in_sign_i, in_exp_i, in_mant_i));
  endtask

  task automatic single(input string tag, input logic s, input int e,
                        input logic [MW-1:0] m, input res_t expv);
    drive(1'b1, s, EXPW'(e), m, 1'b1);
    #1 check({tag, ".in_ready"}, 64'(in_ready_o), 64'd1);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1 check({tag, ".lat1_valid"}, 64'(out_valid_o), 64'd0);
    step();
    #1 check({tag, ".lat2_valid"}, 64'(out_valid_o), 64'd1);
    check_res(tag, observed(), expv);
    step();
  endtask

  logic [EXPW-1:0] b_exp [4];
  logic [MW-1:0]   b_mant[4];
  logic            b_sign[4];

  initial begin
    int   sent;
    int   k;
    int   acc;
    int   cyc;
    int   sel;
    int   ei;
    bit   did_rst;
    bit   stall_prev;
    logic v;
    logic rdy;
    logic [63:0] r64;
    logic [MW-1:0] m;
    res_t held;
    res_t d_exp;

    // Reset
    rst_i   = 1'b1;
    flush_i = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1 check_idle("reset");
    rst_i = 1'b0;
    step();

    // Directed single beats and latency
    single("dir_norm",    1'b1, 100,  bit_at(45), mk(1'b1, 95,   bit_at(50), 1'b0, 1'b0));
    single("dir_clamp",   1'b0, 4,    bit_at(40), mk(1'b0, 1,    bit_at(43), 1'b0, 1'b1));
    single("dir_zero",    1'b0, 500,  '0,         mk(1'b0, 0,    '0,         1'b1, 1'b0));
    single("dir_noshift", 1'b0, 7,    bit_at(50), mk(1'b0, 7,    bit_at(50), 1'b0, 1'b0));
    single("dir_exp1",    1'b1, 1,    bit_at(10), mk(1'b1, 1,    bit_at(10), 1'b0, 1'b1));
    single("dir_expneg",  1'b0, -5,   bit_at(3),  mk(1'b0, -5,   bit_at(3),  1'b0, 1'b1));
    single("dir_maxlz",   1'b0, 4095, bit_at(0),  mk(1'b0, 4045, bit_at(50), 1'b0, 1'b0));
    single("dir_exact",   1'b1, 11,   bit_at(40), mk(1'b1, 1,    bit_at(50), 1'b0, 1'b0));

    // Back-pressure: 4 beats with the output stalled for 4 cycles
    for (int i = 0; i < 4; i++) begin
      b_exp[i]  = EXPW'(200 + i);
      b_mant[i] = bit_at(40 - i) | bit_at(i);
      b_sign[i] = i[0];
    end
    sent = 0;
    n_out = 0;
    for (int c = 0; c < 4; c++) begin
      k = (sent < 4) ? sent : 3;
      drive(sent < 4, b_sign[k], b_exp[k], b_mant[k], 1'b0);
      #1;
      if (c >= 2) check("stall.in_ready_low", 64'(in_ready_o), 64'd0);
      if (c == 2) held = observed();
      if (c == 3) begin
        check("stall.out_valid", 64'(out_valid_o), 64'd1);
        check_res("stall.stable", observed(), held);
      end
      sb_cycle("stall");
      if (in_valid_i && in_ready_o) sent++;
      step();
    end
    check("stall.accepted", 64'(sent), 64'd2);
    for (int c = 0; c < 20 && n_out < 4; c++) begin
      k = (sent < 4) ? sent : 3;
      drive(sent < 4, b_sign[k], b_exp[k], b_mant[k], 1'b1);
      #1 sb_cycle("stall_rel");
      if (in_valid_i && in_ready_o) sent++;
      step();
    end
    check("stall.delivered", 64'(n_out), 64'd4);
    check("stall.queue_empty", 64'(exp_q.size()), 64'd0);

    // Flush with beats in both stages
    drive(1'b1, 1'b0, EXPW'(300), bit_at(30), 1'b0);
    #1 check("flush.acc_a", 64'(in_ready_o), 64'd1);
    step();
    drive(1'b1, 1'b1, EXPW'(301), bit_at(31), 1'b0);
    #1 check("flush.acc_b", 64'(in_ready_o), 64'd1);
    step();
    drive(1'b1, 1'b0, EXPW'(302), bit_at(32), 1'b0);
    flush_i = 1'b1;
    #1 check("flush.full_valid", 64'(out_valid_o), 64'd1);
    step();
    flush_i = 1'b0;
    drive(1'b1, 1'b1, EXPW'(50), bit_at(20), 1'b1);
    d_exp = ref_model(1'b1, EXPW'(50), bit_at(20));
    #1 check("flush.out_valid_cleared", 64'(out_valid_o), 64'd0);
    check("flush.in_ready", 64'(in_ready_o), 64'd1);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    #1 check("flush.d_lat1", 64'(out_valid_o), 64'd0);
    step();
    #1 check("flush.d_lat2", 64'(out_valid_o), 64'd1);
    check_res("flush.d", observed(), d_exp);
    step();
    #1 check("flush.no_ghost", 64'(out_valid_o), 64'd0);
    step();
    exp_q.delete();

    // Random stream against the reference model, with a mid-stream reset
    acc        = 0;
    cyc        = 0;
    did_rst    = 1'b0;
    stall_prev = 1'b0;
    while (acc < 10000 && cyc < 60000) begin
      cyc++;
      v   = ($urandom_range(0, 4) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      sel = int'($urandom_range(0, 2));
      case (sel)
        0:       ei = int'($urandom_range(0, 70)) - 8;
        1:       ei = int'($urandom_range(0, 8191)) - 4096;
        default: ei = int'($urandom_range(0, 2047));
      endcase
      r64 = {$urandom, $urandom};
      m   = r64[MW-1:0] >> $urandom_range(0, MW);
      drive(v, r64[63], EXPW'(ei), m, rdy);
      rst_i = (!did_rst && acc >= 5000);
      #1;
      if (stall_prev) begin
        check("rand.stall_valid", 64'(out_valid_o), 64'd1);
        check_res("rand.stall_stable", observed(), held);
      end
      if (rst_i) begin
        did_rst    = 1'b1;
        stall_prev = 1'b0;
        exp_q.delete();
        step();
        rst_i = 1'b0;
        #1 check_idle("rand.rst");
        continue;
      end
      sb_cycle("rand");
      stall_prev = out_valid_o && !out_ready_i;
      held       = observed();
      if (in_valid_i && in_ready_o) acc++;
      step();
    end
    check("rand.accepted", 64'(acc), 64'd10000);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      #1 sb_cycle("drain");
      step();
    end
    check("rand.queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
